// File: rtl/preg_pkg.sv
// Shared sizing, the physical-register index type and the round-robin
// lane picker for the physical-register allocation arbiter.
package preg_pkg;
    localparam int ARCH     = 32;
    localparam int PHYS     = 64;
    localparam int PW       = $clog2(PHYS);
    localparam int N_FREE   = PHYS - ARCH;
    localparam int NREQ     = 4;
    localparam int LW       = $clog2(NREQ);
    localparam int FQ_DEPTH = 8;
    localparam int QCW      = $clog2(FQ_DEPTH) + 1;
    localparam int FQ_HI    = 6;
    localparam int MAX_WAIT = 4;
    localparam int WCW      = $clog2(MAX_WAIT) + 1;
    localparam int OCW      = $clog2(N_FREE) + 1;

    typedef logic [PW-1:0] preg_t;

    // First set request bit at or above ptr; index wrap relies on NREQ being a power of two.
    function automatic logic [LW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [LW-1:0] ptr);
        logic [LW-1:0] idx;
        logic [LW-1:0] pick;
        pick = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + LW'(i);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/preg_rel_fifo.sv
// Release queue: small FIFO of physical registers awaiting return to the
// free list. A push into a full queue is ignored; same-cycle push+pop is legal.
module preg_rel_fifo
    import preg_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  preg_t                  din,
    input  logic                   pop,
    output preg_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    preg_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/preg_alloc_arbiter.sv
// Sole driver of the physical-register free list: round-robin allocation across
// rename lanes, buffered commit releases, never a pop and a push in one cycle.
module preg_alloc_arbiter
    import preg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output preg_t           gnt_prd,
    input  logic            rel_valid,
    input  preg_t           rel_prd,
    output logic            rel_ready,
    output logic            fl_alloc,
    input  logic            fl_alloc_ok,
    input  preg_t           fl_prd_alloc,
    output logic            fl_free_en,
    output preg_t           fl_prd_free,
    output logic            err_overfree
);
    logic           q_full;
    logic           q_empty;
    logic           q_pop;
    preg_t          q_head;
    logic [QCW-1:0] q_count;
    logic [OCW-1:0] out_cnt;
    logic [WCW-1:0] wait_cnt;
    logic [LW-1:0]  rr_ptr;
    logic [LW-1:0]  lane;
    logic           can_a;
    logic           can_f;
    logic           drop;
    logic           free_win;
    logic           alloc_win;

    preg_rel_fifo #(.DEPTH(FQ_DEPTH)) u_rel_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rel_valid && rel_ready),
        .din   (rel_prd),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // A release with nothing outstanding is dropped rather than pushed, so the free list can never overfill.
    always_comb begin
        can_a     = !rst && (|req) && fl_alloc_ok;
        can_f     = !rst && !q_empty && (out_cnt != '0);
        drop      = !rst && !q_empty && (out_cnt == '0);
        free_win  = can_f && (!can_a || (q_count >= QCW'(FQ_HI)) || (wait_cnt >= WCW'(MAX_WAIT)));
        alloc_win = can_a && !free_win;
        lane      = rr_pick(req, rr_ptr);
    end

    assign rel_ready   = !rst && !q_full;
    assign fl_alloc    = alloc_win;
    assign fl_free_en  = free_win;
    assign fl_prd_free = free_win ? q_head : '0;
    assign q_pop       = free_win || drop;

    // Grant registers, round-robin pointer, outstanding count, free starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= '0;
            gnt_prd      <= '0;
            rr_ptr       <= '0;
            out_cnt      <= '0;
            wait_cnt     <= '0;
            err_overfree <= 1'b0;
        end else begin
            gnt          <= alloc_win ? (NREQ'(1) << lane) : '0;
            err_overfree <= err_overfree || drop;
            if (alloc_win) begin
                gnt_prd <= fl_prd_alloc;
                rr_ptr  <= lane + LW'(1);
                out_cnt <= out_cnt + OCW'(1);
            end else if (free_win) begin
                out_cnt <= out_cnt - OCW'(1);
            end
            if (free_win) begin
                wait_cnt <= '0;
            end else if (alloc_win && can_f) begin
                if (wait_cnt < WCW'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
            end else if (q_empty) begin
                wait_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_preg_alloc_arbiter.sv
// Bench for preg_alloc_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the free list, release queue and arbitration rules.
module tb_preg_alloc_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [5:0] gnt_prd;
    logic       rel_valid;
    logic [5:0] rel_prd;
    logic       rel_ready;
    logic       fl_alloc;
    logic       fl_alloc_ok;
    logic [5:0] fl_prd_alloc;
    logic       fl_free_en;
    logic [5:0] fl_prd_free;
    logic       err_overfree;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         relq[$];
    int         fl[$];
    int         outst;
    int         rr;
    int         lose;
    bit         m_err;
    logic [3:0] m_gnt;
    logic [5:0] m_gnt_prd;
    bit         fl_stall;
    // per-cycle model decisions
    bit         e_alloc, e_free, e_drop, e_canf, e_ready;
    int         e_lane;
    logic [5:0] e_prd_free;

    preg_alloc_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_prd(gnt_prd),
        .rel_valid(rel_valid), .rel_prd(rel_prd), .rel_ready(rel_ready),
        .fl_alloc(fl_alloc), .fl_alloc_ok(fl_alloc_ok), .fl_prd_alloc(fl_prd_alloc),
        .fl_free_en(fl_free_en), .fl_prd_free(fl_prd_free), .err_overfree(err_overfree)
    );

    always #5 clk = ~clk;

    task automatic model_eval();
        bit can_a;
        can_a   = !rst && (req != 4'd0) && fl_alloc_ok;
        e_canf  = !rst && relq.size() > 0 && outst > 0;
        e_drop  = !rst && relq.size() > 0 && outst == 0;
        e_free  = e_canf && (!can_a || relq.size() >= 6 || lose >= 4);
        e_alloc = can_a && !e_free;
        e_ready = !rst && relq.size() < 8;
        e_prd_free = e_free ? 6'(relq[0]) : 6'd0;
        e_lane = 0;
        for (int k = 3; k >= 0; k--) begin
            if (req[(rr + k) % 4]) e_lane = (rr + k) % 4;
        end
    endtask

    task automatic settle();
        fl_alloc_ok  = (fl.size() > 0) && !fl_stall;
        fl_prd_alloc = (fl.size() > 0) ? 6'(fl[0]) : 6'd0;
        #1;
        model_eval();
    endtask

    task automatic tick();
        bit q_was_empty;
        @(posedge clk);
        if (rst) begin
            relq.delete();
            fl.delete();
            for (int i = 32; i < 64; i++) fl.push_back(i);
            outst = 0; rr = 0; lose = 0; m_err = 1'b0;
            m_gnt = 4'd0; m_gnt_prd = 6'd0;
        end else begin
            q_was_empty = (relq.size() == 0);
            if (e_free) begin
                fl.push_back(relq.pop_front());
                outst--;
                lose = 0;
            end else if (e_drop) begin
                void'(relq.pop_front());
                m_err = 1'b1;
            end
            if (e_alloc) begin
                void'(fl.pop_front());
                m_gnt     = 4'(1 << e_lane);
                m_gnt_prd = fl_prd_alloc;
                rr        = (e_lane + 1) % 4;
                outst++;
                if (e_canf) lose = (lose < 4) ? lose + 1 : 4;
            end else begin
                m_gnt = 4'd0;
                if (!e_free && q_was_empty) lose = 0;
            end
            if (rel_valid && e_ready) relq.push_back(int'(rel_prd));
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 4'd0; rel_valid = 1'b0; rel_prd = 6'd0; fl_stall = 1'b0;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; rel_valid = 1'b1; rel_prd = 6'd40; fl_stall = 1'b0;
        settle();
        tick();
        settle();
        checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (gnt_prd !== 6'd0) begin failures++; $display("FAIL reset_gnt_prd got=%0d exp=0", gnt_prd); end
        checks++; if ({fl_alloc, fl_free_en} !== 2'b00) begin failures++; $display("FAIL reset_fl got=%b exp=00", {fl_alloc, fl_free_en}); end
        checks++; if (err_overfree !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overfree); end
        checks++; if (rel_ready !== 1'b0) begin failures++; $display("FAIL reset_rel_ready got=%b exp=0", rel_ready); end
        tick();
        rst = 1'b0; req = 4'd0; rel_valid = 1'b0;
        settle();
        checks++; if (rel_ready !== 1'b1) begin failures++; $display("FAIL post_reset_rel_ready got=%b exp=1", rel_ready); end
        checks++; if (fl_free_en !== 1'b0) begin failures++; $display("FAIL post_reset_free got=%b exp=0", fl_free_en); end
        tick();
    endtask

    task automatic test_single_alloc();
        apply_reset();
        req = 4'b0001;
        settle();
        checks++; if (fl_alloc !== 1'b1) begin failures++; $display("FAIL single_fl_alloc got=%b exp=1", fl_alloc); end
        tick();
        req = 4'd0;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (gnt_prd !== 6'd32) begin failures++; $display("FAIL single_gnt_prd got=%0d exp=32", gnt_prd); end
        settle();
        checks++; if (fl_alloc !== 1'b0) begin failures++; $display("FAIL single_idle_alloc got=%b exp=0", fl_alloc); end
        tick();
        checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            settle();
            tick();
            checks++; if (gnt !== 4'(1 << i)) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, 4'(1 << i)); end
            checks++; if (gnt_prd !== 6'(32 + i)) begin failures++; $display("FAIL rr_prd%0d got=%0d exp=%0d", i, gnt_prd, 32 + i); end
        end
        req = 4'd0;
    endtask

    task automatic test_exhaust();
        int n;
        apply_reset();
        req = 4'b1111;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (fl_alloc === 1'b1) n++;
            tick();
        end
        checks++; if (n != 32) begin failures++; $display("FAIL exhaust_count got=%0d exp=32", n); end
        checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL exhaust_gnt got=%b exp=0000", gnt); end
        rel_valid = 1'b1; rel_prd = 6'd40;
        settle();
        checks++; if (fl_alloc !== 1'b0) begin failures++; $display("FAIL exhaust_no_alloc got=%b exp=0", fl_alloc); end
        tick();
        rel_valid = 1'b0;
        settle();
        checks++; if ({fl_alloc, fl_free_en} !== 2'b01) begin failures++; $display("FAIL exhaust_free got=%b exp=01", {fl_alloc, fl_free_en}); end
        checks++; if (fl_prd_free !== 6'd40) begin failures++; $display("FAIL exhaust_free_prd got=%0d exp=40", fl_prd_free); end
        tick();
        settle();
        checks++; if (fl_alloc !== 1'b1) begin failures++; $display("FAIL exhaust_resume got=%b exp=1", fl_alloc); end
        tick();
        checks++; if (gnt !== 4'b0001 || gnt_prd !== 6'd40) begin failures++; $display("FAIL exhaust_regrant got=%b/%0d exp=0001/40", gnt, gnt_prd); end
        req = 4'd0;
    endtask

    task automatic test_free_priority();
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin settle(); tick(); end
        for (int i = 0; i < 30; i++) begin
            rel_valid = (i < 20);
            rel_prd   = 6'(32 + i);
            settle();
            checks++; if (fl_alloc !== e_alloc || fl_free_en !== e_free) begin
                failures++; $display("FAIL prio_arb cyc=%0d got=%b%b exp=%b%b qcnt=%0d", i, fl_alloc, fl_free_en, e_alloc, e_free, relq.size());
            end
            checks++; if (fl_alloc === 1'b1 && fl_free_en === 1'b1) begin failures++; $display("FAIL prio_both cyc=%0d got=11 exp=not both", i); end
            tick();
        end
        rel_valid = 1'b0; req = 4'd0;
    endtask

    task automatic test_wait_limit();
        apply_reset();
        req = 4'b1111; rel_valid = 1'b1; rel_prd = 6'd45;
        settle();
        tick();
        rel_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            settle();
            if (i < 5) begin
                checks++; if ({fl_alloc, fl_free_en} !== 2'b10) begin failures++; $display("FAIL wait_alloc%0d got=%b exp=10", i, {fl_alloc, fl_free_en}); end
            end else begin
                checks++; if ({fl_alloc, fl_free_en} !== 2'b01 || fl_prd_free !== 6'd45) begin
                    failures++; $display("FAIL wait_free got=%b/%0d exp=01/45", {fl_alloc, fl_free_en}, fl_prd_free);
                end
            end
            tick();
        end
        req = 4'd0;
    endtask

    task automatic test_overfree();
        apply_reset();
        rel_valid = 1'b1; rel_prd = 6'd40;
        settle();
        tick();
        rel_valid = 1'b0;
        settle();
        checks++; if (fl_free_en !== 1'b0) begin failures++; $display("FAIL overfree_push got=%b exp=0", fl_free_en); end
        tick();
        checks++; if (err_overfree !== 1'b1) begin failures++; $display("FAIL overfree_err got=%b exp=1", err_overfree); end
        for (int i = 0; i < 8; i++) begin
            rel_valid = 1'b1; rel_prd = 6'(48 + i);
            settle();
            checks++; if (rel_ready !== 1'b1 || fl_free_en !== 1'b0) begin
                failures++; $display("FAIL overfree_burst%0d got=%b%b exp=10", i, rel_ready, fl_free_en);
            end
            tick();
        end
        req = 4'b1111; rel_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin settle(); tick(); end
        rst = 1'b1;
        settle();
        tick();
        checks++; if (gnt !== 4'd0 || rel_ready !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b exp=0000/0", gnt, rel_ready); end
        rst = 1'b0; req = 4'd0; rel_valid = 1'b0;
        settle();
        checks++; if (fl_free_en !== 1'b0) begin failures++; $display("FAIL midrst_free got=%b exp=0", fl_free_en); end
        tick();
        checks++; if (err_overfree !== 1'b0) begin failures++; $display("FAIL midrst_queue_err got=%b exp=0", err_overfree); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            req = req & ~m_gnt;
            if ($urandom_range(0, 2) == 0) req = req | 4'($urandom);
            if ($urandom_range(0, 15) == 0) req = 4'd0;
            rel_valid = ($urandom_range(0, 2) == 0);
            rel_prd   = 6'($urandom_range(32, 63));
            fl_stall  = ($urandom_range(0, 7) == 0);
            settle();
            checks++; if (fl_alloc !== e_alloc || fl_free_en !== e_free) begin
                failures++; $display("FAIL rand_arb cyc=%0d got=%b%b exp=%b%b", i, fl_alloc, fl_free_en, e_alloc, e_free);
            end
            checks++; if (fl_prd_free !== e_prd_free) begin failures++; $display("FAIL rand_prd_free cyc=%0d got=%0d exp=%0d", i, fl_prd_free, e_prd_free); end
            checks++; if (rel_ready !== e_ready) begin failures++; $display("FAIL rand_rel_ready cyc=%0d got=%b exp=%b", i, rel_ready, e_ready); end
            tick();
            checks++; if (gnt !== m_gnt) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", i, gnt, m_gnt); end
            if (m_gnt != 4'd0) begin
                checks++; if (gnt_prd !== m_gnt_prd) begin failures++; $display("FAIL rand_gnt_prd cyc=%0d got=%0d exp=%0d", i, gnt_prd, m_gnt_prd); end
            end
            checks++; if (err_overfree !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, err_overfree, m_err); end
        end
        req = 4'd0; rel_valid = 1'b0; fl_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alloc();
        test_round_robin();
        test_exhaust();
        test_free_priority();
        test_wait_limit();
        test_overfree();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
